// File: rtl/button_conditioner.sv
// button_conditioner: input stage for the door-lock FSM.
// Synchronises ten digit buttons plus start/done, debounces them as one 12-bit
// vector and emits exactly one single-cycle pulse per qualified press.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-low reset
//   button       raw digit buttons, bit i = digit i
//   start_btn    raw start button
//   done_btn     raw done button
//   key_valid    one-cycle pulse, single digit press accepted
//   key_code     last accepted digit, holds between pulses
//   start_pulse  one-cycle pulse, start press accepted
//   done_pulse   one-cycle pulse, done press accepted
//   key_err      one-cycle pulse, accepted vector had more than one bit set
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] button,
  input  logic       start_btn,
  input  logic       done_btn,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       start_pulse,
  output logic       done_pulse,
  output logic       key_err
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW:0] CntMax = (CntW + 1)'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} state_e;

  state_e          state_q, state_d;
  logic [11:0]     sync1_q, sync2_q;
  logic [11:0]     snap_q, snap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [11:0]     s;
  logic [CntW:0]   cnt_inc;
  logic            cnt_reach;
  logic [CntW-1:0] cnt_sat;
  logic            accept;
  logic            one_hot;
  logic [3:0]      digit_idx;

  assign s = sync2_q;

  // One extra bit so the increment never overflows before the compare.
  assign cnt_inc   = {1'b0, cnt_q} + (CntW + 1)'(1);
  assign cnt_reach = (cnt_inc >= CntMax);
  assign cnt_sat   = cnt_reach ? CntMax[CntW-1:0] : cnt_inc[CntW-1:0];

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s != '0) begin
          snap_d  = s;
          cnt_d   = CntOne;
          state_d = StPressWait;
        end
      end
      StPressWait: begin
        if (s == '0) begin
          state_d = StIdle;
        end else if (s != snap_q) begin
          // Pattern changed (bounce or extra button): restart qualification.
          snap_d = s;
          cnt_d  = CntOne;
        end else begin
          cnt_d = cnt_sat;
          if (cnt_reach) begin
            accept  = 1'b1;
            state_d = StHeld;
          end
        end
      end
      StHeld: begin
        if (s == '0) begin
          cnt_d   = CntOne;
          state_d = StRelWait;
        end
      end
      StRelWait: begin
        if (s != '0) begin
          state_d = StHeld;
        end else begin
          cnt_d = cnt_sat;
          if (cnt_reach) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_hot = (snap_q != '0) && ((snap_q & (snap_q - 12'd1)) == '0);

  always_comb begin
    digit_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (snap_q[i]) digit_idx = 4'(i);
    end
  end

  always_comb begin
    key_valid_d = accept && one_hot && (snap_q[9:0] != '0);
    start_d     = accept && one_hot && snap_q[10];
    done_d      = accept && one_hot && snap_q[11];
    err_d       = accept && !one_hot;
    key_code_d  = key_valid_d ? digit_idx : key_code_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sync1_q     <= '0;
      sync2_q     <= '0;
      snap_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= {done_btn, start_btn, button};
      sync2_q     <= sync1_q;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign start_pulse = start_q;
  assign done_pulse  = done_q;
  assign key_err     = err_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: expected pulses (kind, code,
// cycle) are queued when a press is driven and popped when a pulse appears.
module tb_button_conditioner;

  localparam int unsigned D = 4;

  typedef struct {
    int kind;  // 0 key, 1 start, 2 done, 3 err
    int code;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] raw = '0;
  logic [9:0]  button;
  logic        start_btn;
  logic        done_btn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start_pulse;
  logic        done_pulse;
  logic        key_err;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   model_code = 0;
  exp_t sb[$];

  assign button    = raw[9:0];
  assign start_btn = raw[10];
  assign done_btn  = raw[11];

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .start_btn  (start_btn),
    .done_btn   (done_btn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start_pulse(start_pulse),
    .done_pulse (done_pulse),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin : mon
    int   act;
    exp_t e;
    if (!rst) begin
      model_code = 0;
    end else if (key_valid || start_pulse || done_pulse || key_err) begin
      act = key_valid ? 0 : start_pulse ? 1 : done_pulse ? 2 : 3;
      check_eq("one_pulse", $countones({key_valid, start_pulse, done_pulse, key_err}), 1);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse_kind", act, -1);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", act, e.kind);
        check_eq("pulse_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          check_eq("key_code", int'(key_code), e.code);
          model_code = e.code;
        end else begin
          check_eq("key_code_held", int'(key_code), model_code);
        end
      end
    end
  end

  task automatic push_exp(input int kind, input int code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.cyc  = cyc + 2 + int'(D);
    sb.push_back(e);
  endtask

  // Drive vec for `hold` sampling edges, then release for `gap` cycles.
  // kind < 0 means no pulse is expected.
  task automatic press(input logic [11:0] vec, input int hold, input int gap,
                       input int kind, input int code);
    @(negedge clk);
    raw = vec;
    if (kind >= 0) push_exp(kind, code);
    repeat (hold) @(negedge clk);
    raw = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_key_valid"}, int'(key_valid), 0);
    check_eq({tag, "_key_code"}, int'(key_code), 0);
    check_eq({tag, "_start"}, int'(start_pulse), 0);
    check_eq({tag, "_done"}, int'(done_pulse), 0);
    check_eq({tag, "_err"}, int'(key_err), 0);
  endtask

  initial begin
    // Reset held with digit 8 down.
    rst = 1'b0;
    raw = 12'h100;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    push_exp(0, 8);
    repeat (8) @(negedge clk);
    raw = '0;
    repeat (8) @(negedge clk);

    // Start, digits 8/4/0, done.
    press(12'h400, 5, 5, 1, 0);
    press(12'h100, 5, 5, 0, 8);
    press(12'h010, 5, 5, 0, 4);
    press(12'h001, 5, 5, 0, 0);
    press(12'h800, 5, 5, 2, 0);

    // Bounce on digit 7, then steady.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raw = (i % 2 == 0) ? 12'h080 : 12'h000;
    end
    press(12'h080, 5, 8, 0, 7);

    // Too-short press.
    press(12'h008, 3, 8, -1, 0);
    check_eq("short_code_held", int'(key_code), 7);

    // Two digits at once.
    press(12'h012, 5, 8, 3, 0);
    check_eq("multi_code_held", int'(key_code), 7);

    // Digit 5 held, digit 2 added then dropped: one pulse only.
    @(negedge clk);
    raw = 12'h020;
    push_exp(0, 5);
    repeat (8) @(negedge clk);
    raw = 12'h024;
    repeat (6) @(negedge clk);
    raw = 12'h020;
    repeat (4) @(negedge clk);
    raw = '0;
    repeat (10) @(negedge clk);
    press(12'h004, 5, 8, 0, 2);

    // Async reset pulse between edges during PRESS_WAIT of digit 9.
    @(negedge clk);
    raw = 12'h200;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    raw = '0;
    #1;
    check_outputs_zero("async_rst");
    #2;
    rst = 1'b1;
    repeat (15) @(negedge clk);

    // Normal operation after reset.
    press(12'h002, 5, 8, 0, 1);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
